minterm_scan_ctrl: RTL and testbench



---
 rtl/minterm_scan_ctrl_if.sv | 24 ++
 rtl/minterm_scan_ctrl.sv | 78 +++++++
 tb/tb_minterm_scan_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/minterm_scan_ctrl_if.sv
// minterm_scan_ctrl_if: handshake, select and result bundle between a scan host and the minterm scan controller
interface minterm_scan_ctrl_if #(parameter int N_IN = 4);
  localparam int W = 1 << N_IN;
  logic start;
  logic abort;
  logic f_in;
  logic [W-1:0] expected;
  logic [N_IN-1:0] sel;
  logic en_out;
  logic busy;
  logic done;
  logic [W-1:0] mask;
  logic match;
  logic mismatch_valid;
  logic [N_IN-1:0] mismatch_idx;
  modport master (
    output start, abort, f_in, expected,
    input sel, en_out, busy, done, mask, match, mismatch_valid, mismatch_idx
  );
  modport slave (
    input start, abort, f_in, expected,
    output sel, en_out, busy, done, mask, match, mismatch_valid, mismatch_idx
  );
endinterface

// File: rtl/minterm_scan_ctrl.sv
// minterm_scan_ctrl: walks sel through every minterm, samples f_in after SETTLE cycles and checks the mask
module minterm_scan_ctrl #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  minterm_scan_ctrl_if.slave bus
);
  localparam int W = 1 << N_IN;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic go, sample, last;
  logic [W-1:0] mask_smp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (go ? SCAN : IDLE) :
                state == SCAN ? (bus.abort ? IDLE : (sample && last) ? DONE : SCAN) :
                IDLE;
  end
  // abort outranks a coinciding sample edge, so sample is masked by it
  always_comb begin
    go = state == IDLE && bus.start && !bus.abort;
    sample = state == SCAN && !bus.abort && cnt == 4'(SETTLE - 1);
    last = &bus.sel;
    mask_smp = bus.mask;
    mask_smp[bus.sel] = bus.f_in;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.sel <= '0;
      bus.en_out <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.mask <= '0;
      bus.match <= 1'b0;
      bus.mismatch_valid <= 1'b0;
      bus.mismatch_idx <= '0;
      cnt <= '0;
    end else begin
      bus.done <= state_nxt == DONE;
      if (go) begin
        bus.sel <= '0;
        bus.en_out <= 1'b1;
        bus.busy <= 1'b1;
        bus.mask <= '0;
        bus.match <= 1'b0;
        bus.mismatch_valid <= 1'b0;
        bus.mismatch_idx <= '0;
        cnt <= '0;
      end else if (state == SCAN && bus.abort) begin
        bus.sel <= '0;
        bus.en_out <= 1'b0;
        bus.busy <= 1'b0;
        cnt <= '0;
      end else if (sample) begin
        bus.mask <= mask_smp;
        if (bus.f_in != bus.expected[bus.sel] && !bus.mismatch_valid) begin
          bus.mismatch_valid <= 1'b1;
          bus.mismatch_idx <= bus.sel;
        end
        cnt <= '0;
        if (last) begin
          bus.sel <= '0;
          bus.en_out <= 1'b0;
          bus.busy <= 1'b0;
          bus.match <= mask_smp == bus.expected;
        end else begin
          bus.sel <= bus.sel + N_IN'(1);
        end
      end else if (state == SCAN) begin
        cnt <= cnt + 4'd1;
      end
    end
endmodule

// File: tb/tb_minterm_scan_ctrl.sv
// tb_minterm_scan_ctrl: randomized scans of truth tables against a mask/first-difference reference model
module tb_minterm_scan_ctrl;
  localparam int N = 4;
  localparam int S = 2;
  localparam int W = 1 << N;
  localparam int STEPS = W * S;
  localparam logic [W-1:0] PRIME = 16'h28AC;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [W-1:0] func = '0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  minterm_scan_ctrl_if #(.N_IN(N)) bus ();
  minterm_scan_ctrl #(.N_IN(N), .SETTLE(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  assign bus.f_in = func[bus.sel];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b, input int n);
    for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
    return -1;
  endfunction
  task automatic check_zero(input string tag);
    check({tag, "_sel"}, 32'(bus.sel), 0);
    check({tag, "_en"}, 32'(bus.en_out), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_mask"}, 32'(bus.mask), 0);
    check({tag, "_match"}, 32'(bus.match), 0);
    check({tag, "_mv"}, 32'(bus.mismatch_valid), 0);
    check({tag, "_midx"}, 32'(bus.mismatch_idx), 0);
  endtask
  // mode 0: full scan, 1: abort at step k==at, 2: async reset between edges at step k==at
  task automatic scan(input logic [W-1:0] f, input logic [W-1:0] e, input int mode, input int at);
    int n;
    int d;
    logic [W-1:0] m;
    @(negedge clk);
    func = f;
    bus.expected = e;
    bus.abort = 1'b0;
    check("pre_done", 32'(bus.done), 0);
    check("pre_busy", 32'(bus.busy), 0);
    bus.start = 1'b1;
    for (int k = 0; k < STEPS; k++) begin
      @(negedge clk);
      bus.start = 1'($urandom_range(0, 1));
      if (k == 0) begin
        check("clr_mask", 32'(bus.mask), 0);
        check("clr_match", 32'(bus.match), 0);
        check("clr_mv", 32'(bus.mismatch_valid), 0);
      end
      check("scan_sel", 32'(bus.sel), k / S);
      check("scan_en", 32'(bus.en_out), 1);
      check("scan_busy", 32'(bus.busy), 1);
      check("scan_done", 32'(bus.done), 0);
      if (mode == 1 && k == at) begin
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        n = k / S;
        m = f & W'((32'd1 << n) - 1);
        d = first_diff(f, e, n);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_en", 32'(bus.en_out), 0);
        check("abort_sel", 32'(bus.sel), 0);
        check("abort_mask", 32'(bus.mask), 32'(m));
        check("abort_match", 32'(bus.match), 0);
        check("abort_mv", 32'(bus.mismatch_valid), d >= 0 ? 1 : 0);
        check("abort_midx", 32'(bus.mismatch_idx), d >= 0 ? d : 0);
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", 32'(bus.done), 0);
        end
        return;
      end
      if (mode == 2 && k == at) begin
        #2 rst_n = 1'b0;
        #1 check_zero("rst_mid");
        bus.start = 1'b0;
        #3 rst_n = 1'b1;
        return;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    d = first_diff(f, e, W);
    check("end_done", 32'(bus.done), 1);
    check("end_busy", 32'(bus.busy), 0);
    check("end_en", 32'(bus.en_out), 0);
    check("end_sel", 32'(bus.sel), 0);
    check("end_mask", 32'(bus.mask), 32'(f));
    check("end_match", 32'(bus.match), f == e ? 1 : 0);
    check("end_mv", 32'(bus.mismatch_valid), d >= 0 ? 1 : 0);
    check("end_midx", 32'(bus.mismatch_idx), d >= 0 ? d : 0);
  endtask
  initial begin
    logic [W-1:0] f;
    logic [W-1:0] e;
    int mode;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.expected = '0;
    #1 rst_n = 1'b0;
    #2 check_zero("rst");
    #4 rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_en", 32'(bus.en_out), 0);
      check("idle_busy", 32'(bus.busy), 0);
    end
    scan(PRIME, PRIME, 0, 0);
    scan('0, PRIME, 0, 0);
    scan(PRIME, PRIME, 1, 5 * S);
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("sa_busy", 32'(bus.busy), 0);
    check("sa_en", 32'(bus.en_out), 0);
    @(negedge clk);
    check("sa_busy2", 32'(bus.busy), 0);
    scan(PRIME, PRIME ^ 16'h0100, 0, 0);
    scan(PRIME, PRIME, 0, 0);
    scan(PRIME, PRIME, 2, 9 * S);
    scan(PRIME, PRIME, 0, 0);
    repeat (24) begin
      f = W'($urandom);
      case ($urandom_range(0, 2))
        0: e = f;
        1: e = f ^ W'(32'd1 << $urandom_range(0, W - 1));
        default: e = W'($urandom);
      endcase
      mode = $urandom_range(0, 3);
      scan(f, e, mode > 2 ? 0 : mode, $urandom_range(0, STEPS - 1));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
